// File: rtl/linear_sensor_sequencer.sv
// Readout sequencer for clocked linear image sensors: sensor clock / SI generation, per-pixel ADC
// capture and a 2-entry ready/valid output buffer. Optional macro: LINEAR_SENSOR_TEST_PATTERN_EN.
module linear_sensor_sequencer #(
    parameter int unsigned NUM_PIXELS         = 128,
    parameter int unsigned NUM_CH             = 1,
    parameter int unsigned DATA_WIDTH         = 12,
    parameter int unsigned CLK_DIV            = 100,
    parameter int unsigned SI_WIDTH_NCLK      = 4,
    parameter int unsigned LEAD_PIXELS        = 18,
    parameter int unsigned SAMPLE_OFFSET_NCLK = 35,
    parameter int unsigned IDX_WIDTH          = $clog2(NUM_PIXELS)
) (
    input  logic                         master_clock,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic [15:0]                  gap_nclk,
    input  logic                         test_mode,
    output logic                         sensor_clk,
    output logic                         sensor_si,
    input  logic [NUM_CH*DATA_WIDTH-1:0] adc_data,
    output logic [NUM_CH*DATA_WIDTH-1:0] m_data,
    output logic [IDX_WIDTH-1:0]         m_index,
    output logic                         m_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         busy,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    localparam int unsigned DW = NUM_CH * DATA_WIDTH;
    localparam int unsigned EW = 1 + IDX_WIDTH + DW;
    localparam int unsigned PW = $clog2(2 * CLK_DIV);

    localparam logic [PW-1:0] PhLow     = PW'(CLK_DIV);
    localparam logic [PW-1:0] PhHighEnd = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PhEnd     = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PhSi      = PW'(2 * CLK_DIV - SI_WIDTH_NCLK);
    localparam logic [PW-1:0] PhSample  = PW'(SAMPLE_OFFSET_NCLK);
    localparam logic [15:0]   LeadLast  = 16'(LEAD_PIXELS - 1);
    localparam logic [15:0]   PixLast   = 16'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {StIdle, StPre, StLead, StRead, StGap} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   gap_q, gap_d;
    logic          sclk_q, sclk_d;
    logic          si_q, si_d;
    logic          busy_q, busy_d;
    logic [EW-1:0] out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic [EW-1:0] skid_q, skid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          overrun_q, overrun_d;

    logic          clk_end, cap, pop, drop;
    logic [DW-1:0] cap_data;
    logic [EW-1:0] cap_entry;

`ifdef LINEAR_SENSOR_TEST_PATTERN_EN
    always_comb begin
        cap_data = adc_data;
        if (test_mode) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                cap_data[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(cnt_q) + DATA_WIDTH'(c);
            end
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign cap_data = adc_data;
`endif

    assign clk_end   = (phase_q == PhEnd);
    assign cap       = (state_q == StRead) && (phase_q == PhSample);
    assign cap_entry = {cnt_q == PixLast, cnt_q[IDX_WIDTH-1:0], cap_data};
    assign pop       = out_valid_q & m_ready;

    // Phase keeps free-running across state changes; PRE is the low half of a sensor clock.
    always_comb begin
        state_d = state_q;
        phase_d = clk_end ? '0 : phase_q + PW'(1);
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        case (state_q)
            StIdle: begin
                phase_d = '0;
                if (enable) begin
                    state_d = StPre;
                    phase_d = PhLow;
                    gap_d   = gap_nclk;
                end
            end
            StPre: begin
                if (clk_end) begin
                    cnt_d   = '0;
                    state_d = (LEAD_PIXELS == 0) ? StRead : StLead;
                end
            end
            StLead: begin
                if (clk_end) begin
                    if (cnt_q == LeadLast) begin
                        cnt_d   = '0;
                        state_d = StRead;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StRead: begin
                if (clk_end) begin
                    if (cnt_q == PixLast) begin
                        cnt_d   = '0;
                        state_d = StGap;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StGap: begin
                // Leave after the high half of the clock that follows the gap clocks.
                if ((cnt_q == gap_q) && (phase_q == PhHighEnd)) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = StPre;
                        gap_d   = gap_nclk;
                    end else begin
                        state_d = StIdle;
                        phase_d = '0;
                    end
                end else if (clk_end) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
        sclk_d = busy_d && (phase_d < PhLow);
        si_d   = (state_d == StPre) && (phase_d >= PhSi);
    end

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        drop         = 1'b0;
        if (pop) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                skid_valid_d = cap;
                if (cap) skid_d = cap_entry;
            end else begin
                out_valid_d = cap;
                if (cap) out_d = cap_entry;
            end
        end else if (cap) begin
            if (!out_valid_q) begin
                out_d       = cap_entry;
                out_valid_d = 1'b1;
            end else if (!skid_valid_q) begin
                skid_d       = cap_entry;
                skid_valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        overrun_d = (overrun_q & ~overrun_clr) | drop;
    end

    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            sclk_q       <= 1'b0;
            si_q         <= 1'b0;
            busy_q       <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            sclk_q       <= sclk_d;
            si_q         <= si_d;
            busy_q       <= busy_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sensor_clk                = sclk_q;
    assign sensor_si                 = si_q;
    assign busy                      = busy_q;
    assign m_valid                   = out_valid_q;
    assign overrun                   = overrun_q;
    assign {m_last, m_index, m_data} = out_q;

endmodule

// File: tb/tb_linear_sensor_sequencer.sv
// Bench for linear_sensor_sequencer: random ADC data, timing and beats checked against an
// arithmetic frame model (sample k of a frame starting at S is taken in cycle S+CD+2*CD*(LEAD+k)+SO).
module tb_linear_sensor_sequencer;
    localparam int NP = 8, NC = 2, DW = 12, CD = 4, SIW = 2, LEAD = 2, SO = 5, IW = 3;
    localparam int AW = NC * DW;
    localparam int MAXC = 2048;
`ifdef LINEAR_SENSOR_TEST_PATTERN_EN
    localparam bit TP_EN = 1'b1;
`else
    localparam bit TP_EN = 1'b0;
`endif

    logic clk = 1'b0, resetn = 1'b0, enable = 1'b0, test_mode = 1'b0;
    logic m_ready = 1'b0, overrun_clr = 1'b0;
    logic [15:0] gap_nclk = 16'd0;
    logic [AW-1:0] adc_data = '0, m_data;
    logic [IW-1:0] m_index;
    logic sensor_clk, sensor_si, m_last, m_valid, busy, overrun;

    always #5 clk = ~clk;

    linear_sensor_sequencer #(
        .NUM_PIXELS(NP), .NUM_CH(NC), .DATA_WIDTH(DW), .CLK_DIV(CD), .SI_WIDTH_NCLK(SIW),
        .LEAD_PIXELS(LEAD), .SAMPLE_OFFSET_NCLK(SO), .IDX_WIDTH(IW)
    ) dut (
        .master_clock(clk), .resetn(resetn), .enable(enable), .gap_nclk(gap_nclk),
        .test_mode(test_mode), .sensor_clk(sensor_clk), .sensor_si(sensor_si),
        .adc_data(adc_data), .m_data(m_data), .m_index(m_index), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    typedef struct {
        logic [AW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
        int            t;
    } beat_t;

    int checks = 0, errors = 0, n = 0;
    logic busy_log [MAXC];
    logic si_log   [MAXC];
    logic sclk_log [MAXC];
    logic tm_hist  [MAXC];
    logic [AW-1:0] adc_hist [MAXC];
    beat_t beats [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One master cycle: log a handshake at this edge, then record outputs and drive new ADC data.
    task automatic step();
        if (n < MAXC) tm_hist[n] = test_mode;
        if (m_valid === 1'b1 && m_ready === 1'b1) beats.push_back('{m_data, m_index, m_last, n});
        @(posedge clk);
        #1;
        n++;
        if (n < MAXC) begin
            busy_log[n] = busy;
            si_log[n]   = sensor_si;
            sclk_log[n] = sensor_clk;
            adc_data    = AW'({$urandom(), $urandom()});
            adc_hist[n] = adc_data;
        end
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    function automatic int frame_len(input int g);
        return 2 * CD * (1 + LEAD + NP + g);
    endfunction

    function automatic int cap_cycle(input int s, input int k);
        return s + CD + 2 * CD * (LEAD + k) + SO;
    endfunction

    function automatic logic [AW-1:0] exp_data(input int c, input int k);
        logic [AW-1:0] pat;
        pat = {DW'(k + 1), DW'(k)};
        return (TP_EN && tm_hist[c] === 1'b1) ? pat : adc_hist[c];
    endfunction

    task automatic check_frame(input string tag, input int s, input int g, input bit ends_idle);
        int len;
        len = frame_len(g);
        for (int c = s; c < s + len; c++) begin
            int rel;
            rel = c - s;
            chk($sformatf("%s_busy@%0d", tag, rel), 64'(busy_log[c]), 64'(1));
            chk($sformatf("%s_si@%0d", tag, rel), 64'(si_log[c]),
                64'(rel >= CD - SIW && rel < CD));
            chk($sformatf("%s_sclk@%0d", tag, rel), 64'(sclk_log[c]),
                64'(rel >= CD && ((rel - CD) % (2 * CD)) < CD));
        end
        if (ends_idle) begin
            for (int c = s + len; c < s + len + 2; c++) begin
                chk($sformatf("%s_idle_busy@%0d", tag, c - s), 64'(busy_log[c]), 64'(0));
                chk($sformatf("%s_idle_sclk@%0d", tag, c - s), 64'(sclk_log[c]), 64'(0));
                chk($sformatf("%s_idle_si@%0d", tag, c - s), 64'(si_log[c]), 64'(0));
            end
        end
    endtask

    task automatic check_beat(input string tag, input int s, input int k, input bit timed);
        beat_t b;
        int c;
        c = cap_cycle(s, k);
        chk($sformatf("%s_beat%0d_present", tag, k), 64'(beats.size() > 0), 64'(1));
        if (beats.size() > 0) begin
            b = beats.pop_front();
            chk($sformatf("%s_beat%0d_idx", tag, k), 64'(b.idx), 64'(k));
            chk($sformatf("%s_beat%0d_last", tag, k), 64'(b.last), 64'(k == NP - 1));
            chk($sformatf("%s_beat%0d_data", tag, k), 64'(b.data), 64'(exp_data(c, k)));
            if (timed) chk($sformatf("%s_beat%0d_time", tag, k), 64'(b.t), 64'(c + 1));
        end
    endtask

    initial begin
        int s, g2, len1, len2;

        // Reset state
        repeat (3) step();
        chk("rst_sclk", 64'(sensor_clk), 64'(0));
        chk("rst_si", 64'(sensor_si), 64'(0));
        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_overrun", 64'(overrun), 64'(0));
        chk("rst_last", 64'(m_last), 64'(0));
        resetn = 1'b1;
        repeat (2) step();

        // Continuous frames, gap 0; enable dropped at pixel 4 of the second frame
        m_ready = 1'b1; gap_nclk = 16'd0; enable = 1'b1;
        s = n + 1;
        run_to(cap_cycle(s + frame_len(0), 4));
        enable = 1'b0;
        run_to(s + 2 * frame_len(0) + 4);
        check_frame("a0", s, 0, 1'b0);
        check_frame("a1", s + frame_len(0), 0, 1'b1);
        for (int k = 0; k < NP; k++) check_beat("a0", s, k, 1'b1);
        for (int k = 0; k < NP; k++) check_beat("a1", s + frame_len(0), k, 1'b1);
        chk("a_extra_beats", 64'(beats.size()), 64'(0));

        // Backpressure: third capture dropped with overrun_clr in the same cycle
        m_ready = 1'b0; enable = 1'b1;
        s = n + 1;
        step();
        enable = 1'b0;
        run_to(cap_cycle(s, 2));
        overrun_clr = 1'b1;
        step();
        chk("b_overrun_set", 64'(overrun), 64'(1));
        chk("b_hold_valid", 64'(m_valid), 64'(1));
        chk("b_hold_idx", 64'(m_index), 64'(0));
        chk("b_hold_data", 64'(m_data), 64'(exp_data(cap_cycle(s, 0), 0)));
        step();
        chk("b_overrun_clr", 64'(overrun), 64'(0));
        overrun_clr = 1'b0;
        run_to(cap_cycle(s, 3));
        m_ready = 1'b1;
        step();
        chk("b_full_pop_cap", 64'(overrun), 64'(0));
        run_to(s + frame_len(0) + 4);
        check_frame("b", s, 0, 1'b1);
        check_beat("b", s, 0, 1'b0);
        check_beat("b", s, 1, 1'b0);
        for (int k = 3; k < NP; k++) check_beat("b", s, k, 1'b0);
        chk("b_extra_beats", 64'(beats.size()), 64'(0));
        chk("b_overrun_end", 64'(overrun), 64'(0));

        // Gap 3, then a random gap written mid-frame that must apply only to the next frame
        g2 = $urandom_range(0, 2);
        gap_nclk = 16'd3; enable = 1'b1;
        s = n + 1;
        len1 = frame_len(3);
        len2 = frame_len(g2);
        run_to(s + 30);
        gap_nclk = 16'(g2);
        run_to(s + len1 + 10);
        enable = 1'b0;
        run_to(s + len1 + len2 + 4);
        check_frame("c0", s, 3, 1'b0);
        check_frame("c1", s + len1, g2, 1'b1);
        for (int k = 0; k < NP; k++) check_beat("c0", s, k, 1'b1);
        for (int k = 0; k < NP; k++) check_beat("c1", s + len1, k, 1'b1);
        chk("c_extra_beats", 64'(beats.size()), 64'(0));

        // Asynchronous reset mid-READ, then a clean frame with test_mode set
        gap_nclk = 16'd0; enable = 1'b1;
        s = n + 1;
        run_to(s + 40);
        #3 resetn = 1'b0;
        #1;
        chk("e_rst_sclk", 64'(sensor_clk), 64'(0));
        chk("e_rst_si", 64'(sensor_si), 64'(0));
        chk("e_rst_valid", 64'(m_valid), 64'(0));
        chk("e_rst_busy", 64'(busy), 64'(0));
        chk("e_rst_overrun", 64'(overrun), 64'(0));
        beats.delete();
        repeat (2) step();
        test_mode = 1'b1;
        resetn = 1'b1;
        s = n + 1;
        step();
        enable = 1'b0;
        run_to(s + frame_len(0) + 4);
        check_frame("e", s, 0, 1'b1);
        for (int k = 0; k < NP; k++) check_beat("e", s, k, 1'b1);
        chk("e_extra_beats", 64'(beats.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
